updown_dir_ctrl: RTL and testbench



---
 rtl/updown_dir_ctrl.sv | 114 +++++++++++
 tb/tb_updown_dir_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/updown_dir_ctrl.sv
// Direction controller for a reversible counter: a debounced button toggles the direction,
// or in auto mode the direction reverses one count before each extreme so the counter never wraps.
module updown_dir_ctrl #(
    parameter int CNT_W       = 4,
    parameter int DBNC_CYCLES = 4,
    parameter int DBNC_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn,
    input  logic             mode,
    input  logic [CNT_W-1:0] cnt,
    output logic             up_down,
    output logic             dir_flip,
    output logic             btn_db
);

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  CNT_HI    = CNT_MAX - CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LO    = CNT_W'(1);
    localparam logic [DBNC_W-1:0] DBNC_LAST = DBNC_W'(DBNC_CYCLES - 1);

    // The reversal is taken one count early because the counter still steps once on the flip edge.
    function automatic logic auto_flip(input dir_t dir, input logic [CNT_W-1:0] c);
        logic hit;
        hit = 1'b0;
        if (dir == DIR_UP && c >= CNT_HI)
            hit = 1'b1;
        else if (dir == DIR_DOWN && c <= CNT_LO)
            hit = 1'b1;
        return hit;
    endfunction

    logic              btn_sync_p0;
    logic              btn_sync_p1;
    logic              btn_s;
    logic [DBNC_W-1:0] dbnc_cnt;
    logic [DBNC_W-1:0] dbnc_cnt_nxt;
    logic              btn_db_nxt;
    logic              btn_db_q;
    logic              press;
    dir_t              dir_q;
    dir_t              dir_nxt;
    logic              flip;

    // Stage p0/p1: two-flop synchroniser for the raw button
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_sync_p0 <= 1'b0;
            btn_sync_p1 <= 1'b0;
        end else begin
            btn_sync_p0 <= btn;
            btn_sync_p1 <= btn_sync_p0;
        end
    end

    assign btn_s = btn_sync_p1;

    always_comb begin
        dbnc_cnt_nxt = '0;
        btn_db_nxt   = btn_db;
        if (btn_s != btn_db) begin
            if (dbnc_cnt == DBNC_LAST)
                btn_db_nxt = btn_s;
            else
                dbnc_cnt_nxt = dbnc_cnt + DBNC_W'(1);
        end
    end

    // Debounce stage: level accepted after DBNC_CYCLES consecutive differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbnc_cnt <= '0;
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
        end else begin
            dbnc_cnt <= dbnc_cnt_nxt;
            btn_db   <= btn_db_nxt;
            btn_db_q <= btn_db;
        end
    end

    assign press = btn_db & ~btn_db_q;

    always_comb begin
        flip    = 1'b0;
        dir_nxt = dir_q;
        if (press)
            flip = 1'b1;
        else if (mode)
            flip = auto_flip(dir_q, cnt);
        if (flip)
            dir_nxt = (dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
    end

    // Direction stage: the state register is the up_down output itself
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q    <= DIR_UP;
            dir_flip <= 1'b0;
        end else begin
            dir_q    <= dir_nxt;
            dir_flip <= flip;
        end
    end

    assign up_down = (dir_q == DIR_UP);

endmodule

// File: tb/tb_updown_dir_ctrl.sv
// Directed bench for updown_dir_ctrl with a small reversible counter model driving cnt.
module tb_updown_dir_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             btn = 1'b0;
    logic             mode = 1'b0;
    logic [CNT_W-1:0] cnt;
    logic             up_down;
    logic             dir_flip;
    logic             btn_db;

    logic             cnt_run = 1'b0;
    logic             cnt_load = 1'b0;
    logic [CNT_W-1:0] cnt_load_val = '0;

    int checks = 0;
    int failures = 0;

    updown_dir_ctrl #(.CNT_W(CNT_W), .DBNC_CYCLES(4), .DBNC_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn      (btn),
        .mode     (mode),
        .cnt      (cnt),
        .up_down  (up_down),
        .dir_flip (dir_flip),
        .btn_db   (btn_db)
    );

    always #5 clk = ~clk;

    // Reversible counter model: wraps naturally, so any missed reversal shows up as a wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (cnt_load)
            cnt <= cnt_load_val;
        else if (cnt_run)
            cnt <= up_down ? cnt + CNT_W'(1) : cnt - CNT_W'(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        // Reset, manual mode
        #1 rst_n = 1'b0;
        #2;
        check_val("rst_up_down", 32'(up_down), 1);
        check_val("rst_btn_db", 32'(btn_db), 0);
        check_val("rst_dir_flip", 32'(dir_flip), 0);
        steps(2);
        check_val("rst_hold_up_down", 32'(up_down), 1);
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            check_val("idle_up_down", 32'(up_down), 1);
            check_val("idle_dir_flip", 32'(dir_flip), 0);
            check_val("idle_btn_db", 32'(btn_db), 0);
        end

        // 3-cycle glitch is rejected
        btn = 1'b1;
        steps(3);
        btn = 1'b0;
        for (int k = 4; k <= 12; k++) begin
            step();
            check_val("glitch_btn_db", 32'(btn_db), 0);
            check_val("glitch_up_down", 32'(up_down), 1);
        end

        // Clean press: btn_db after edge 6, toggle after edge 7
        btn = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            check_val("press1_btn_db", 32'(btn_db), (k >= 6) ? 1 : 0);
            check_val("press1_up_down", 32'(up_down), (k >= 7) ? 0 : 1);
            check_val("press1_dir_flip", 32'(dir_flip), (k == 7) ? 1 : 0);
        end
        btn = 1'b0;
        steps(10);
        check_val("release1_btn_db", 32'(btn_db), 0);
        check_val("release1_up_down", 32'(up_down), 0);
        check_val("release1_dir_flip", 32'(dir_flip), 0);

        // Second press returns to up
        btn = 1'b1;
        steps(10);
        check_val("press2_up_down", 32'(up_down), 1);
        btn = 1'b0;
        steps(10);

        // Third press to get down, then abort a debounce in flight with reset
        btn = 1'b1;
        steps(10);
        check_val("press3_up_down", 32'(up_down), 0);
        btn = 1'b0;
        steps(10);
        check_val("press3_rel_btn_db", 32'(btn_db), 0);
        btn = 1'b1;
        steps(4);
        #2 rst_n = 1'b0;
        #1;
        check_val("abort_up_down", 32'(up_down), 1);
        check_val("abort_btn_db", 32'(btn_db), 0);
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            check_val("restart_btn_db", 32'(btn_db), (k >= 6) ? 1 : 0);
            check_val("restart_up_down", 32'(up_down), (k >= 7) ? 0 : 1);
        end
        btn = 1'b0;
        steps(10);

        // Auto ping-pong from reset
        rst_n = 1'b0;
        mode = 1'b1;
        cnt_run = 1'b1;
        step();
        check_val("auto_rst_cnt", 32'(cnt), 0);
        rst_n = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            int exp_cnt;
            step();
            exp_cnt = (k <= 15) ? k : (k <= 30) ? (30 - k) : (k - 30);
            check_val("auto_cnt", 32'(cnt), 32'(exp_cnt));
            check_val("auto_dir_flip", 32'(dir_flip), (k == 15 || k == 30) ? 1 : 0);
            check_val("auto_up_down", 32'(up_down), (k >= 15 && k < 30) ? 0 : 1);
        end

        // Press and auto condition on the same edge give one flip
        rst_n = 1'b0;
        cnt_run = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        btn = 1'b1;
        steps(5);
        check_val("simul_pre_btn_db", 32'(btn_db), 0);
        cnt_load = 1'b1;
        cnt_load_val = 4'd14;
        cnt_run = 1'b1;
        step();
        cnt_load = 1'b0;
        check_val("simul_btn_db", 32'(btn_db), 1);
        check_val("simul_cnt14", 32'(cnt), 14);
        check_val("simul_up", 32'(up_down), 1);
        step();
        check_val("simul_flip_up_down", 32'(up_down), 0);
        check_val("simul_flip_pulse", 32'(dir_flip), 1);
        check_val("simul_cnt15", 32'(cnt), 15);
        step();
        check_val("simul_after_up_down", 32'(up_down), 0);
        check_val("simul_after_pulse", 32'(dir_flip), 0);
        check_val("simul_cnt14b", 32'(cnt), 14);
        step();
        check_val("simul_cnt13", 32'(cnt), 13);
        check_val("simul_late_pulse", 32'(dir_flip), 0);
        cnt_run = 1'b0;
        mode = 1'b0;
        btn = 1'b0;
        steps(10);
        check_val("final_btn_db", 32'(btn_db), 0);
        check_val("final_up_down", 32'(up_down), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
